// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: byte FIFO feeding an 8N1 UART transmitter.
// The parity build is selected by defining UART_TX_PARITY_EN. It inserts an even-parity
// bit after the data bits, so each frame is 11 bit-times (8E1).
// The default build has no parity state and no parity logic.
module uart_tx_serializer #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [7:0]                    TX_DATA,
  input  logic                          TX_VALID,
  output logic                          TX_READY,
  output logic                          TXD,
  output logic                          BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   LEVEL_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   level, level_nxt;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [7:0]       pop_data;
  logic             push, pop, bit_end;
`ifdef UART_TX_PARITY_EN
  logic             par_bit;
`endif

  // Full blocks a push even on an edge where a pop frees a slot.
  assign TX_READY   = (level != LEVEL_FULL);
  assign push       = TX_VALID && TX_READY;
  assign bit_end    = (baud_cnt == BAUD_LAST);
  // Pops only from stored entries (no empty bypass): at idle, or on the last stop-bit cycle.
  assign pop        = (level != '0) &&
                      ((state == S_IDLE) || ((state == S_STOP) && bit_end));
  assign pop_data   = mem[rd_ptr];
  assign FIFO_LEVEL = level;

  // Next stored-byte count from this edge's push/pop pair.
  always_comb begin
    level_nxt = level;
    if (push && !pop)
      level_nxt = level + 1'b1;
    else if (!push && pop)
      level_nxt = level - 1'b1;
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge CLK) begin
    if (push)
      mem[wr_ptr] <= TX_DATA;
  end

  // FIFO pointers and level; depth is a power of two so the pointers wrap naturally.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_nxt;
    end
  end

  // Frame sequencer: start bit, 8 data bits LSB first, optional parity bit, stop bit; registered TXD/BUSY.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= S_IDLE;
      TXD      <= 1'b1;
      BUSY     <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          TXD      <= 1'b1;
          baud_cnt <= '0;
          bit_idx  <= '0;
          BUSY     <= (level_nxt != '0);
          if (pop) begin
            shift   <= pop_data;
`ifdef UART_TX_PARITY_EN
            par_bit <= ^pop_data;
`endif
            TXD     <= 1'b0;
            BUSY    <= 1'b1;
            state   <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            TXD      <= shift[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= bit_idx + 3'd1;
            shift    <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              TXD   <= par_bit;
              state <= S_PARITY;
`else
              TXD   <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              TXD <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            TXD      <= 1'b1;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (pop) begin
              // Back-to-back frame: start bit follows the stop bit with no idle gap.
              shift   <= pop_data;
`ifdef UART_TX_PARITY_EN
              par_bit <= ^pop_data;
`endif
              TXD     <= 1'b0;
              state   <= S_START;
            end else begin
              TXD   <= 1'b1;
              BUSY  <= (level_nxt != '0);
              state <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: begin
          TXD   <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: scoreboard bench for uart_tx_serializer.
// Accepted bytes are queued; a line monitor decodes TXD frames and pops and compares them.
module tb_uart_tx_serializer;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] TX_DATA = 8'h00;
  logic       TX_VALID = 1'b0;
  logic       TX_READY, TXD, BUSY;
  logic [4:0] FIFO_LEVEL;

  uart_tx_serializer #(
    .CLK_FREQ_HZ(1_000_000),
    .BAUD_RATE  (100_000),
    .FIFO_DEPTH (16)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .TX_DATA   (TX_DATA),
    .TX_VALID  (TX_VALID),
    .TX_READY  (TX_READY),
    .TXD       (TXD),
    .BUSY      (BUSY),
    .FIFO_LEVEL(FIFO_LEVEL)
  );

  always #5 CLK = ~CLK;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         frames = 0;
  logic [7:0] exp_q[$];
  int         starts_q[$];
  bit         rec = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Line monitor: a UART receiver sampling every bit at its centre.
  bit         in_frame = 1'b0;
  int         mcnt = 0;
  logic [10:0] fr;
  logic [7:0] e;
  always @(negedge CLK) begin
    if (RESET) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (TXD === 1'b0) begin
        in_frame = 1'b1;
        mcnt = 0;
        fr = '1;
        if (rec) starts_q.push_back(cyc);
      end
    end else begin
      mcnt++;
      if (mcnt % CPB == CPB / 2) begin
        fr[mcnt / CPB] = TXD;
        if (mcnt / CPB == NB - 1) begin
          in_frame = 1'b0;
          frames++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: got data %0h with no byte outstanding", fr[8:1]);
          end else begin
            e = exp_q.pop_front();
            check("start_bit", int'(fr[0]), 0);
            check("frame_data", int'(fr[8:1]), int'(e));
            check("stop_bit", int'(fr[NB-1]), 1);
`ifdef UART_TX_PARITY_EN
            check("parity_bit", int'(fr[9]), $countones(e) % 2);
`endif
          end
        end
      end
    end
  end

  // Offer one byte for one edge; the byte is expected on the line if TX_READY was high.
  task automatic drive_byte(input logic [7:0] d, output bit acc);
    @(negedge CLK);
    TX_VALID = 1'b1;
    TX_DATA  = d;
    #4;
    acc = TX_READY;
    if (acc) exp_q.push_back(d);
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    for (int i = 0; i < maxc && BUSY !== 1'b0; i++) begin
      @(posedge CLK);
      #1;
    end
    check(nm, int'(BUSY), 0);
  endtask

  task automatic single_frame(input logic [7:0] d);
    bit acc;
    drive_byte(d, acc);
    check("single_accept", int'(acc), 1);
    check("txd_idle_at_accept", int'(TXD), 1);
    TX_VALID = 1'b0;
    @(posedge CLK);
    #1;
    check("txd_start_latency", int'(TXD), 0);
    check("busy_in_frame", int'(BUSY), 1);
    check("level_after_pop", int'(FIFO_LEVEL), 0);
`ifdef UART_TX_PARITY_EN
    repeat (9 * CPB + CPB / 2) @(posedge CLK);
    #1;
    check("parity_line", int'(TXD), $countones(d) % 2);
    repeat (CPB / 2 + CPB - 1) @(posedge CLK);
`else
    repeat (NB * CPB - 1) @(posedge CLK);
`endif
    #1;
    check("txd_last_stop_cycle", int'(TXD), 1);
    check("busy_last_cycle", int'(BUSY), 1);
    @(posedge CLK);
    #1;
    check("busy_fall_frame_end", int'(BUSY), 0);
    check("txd_idle_after", int'(TXD), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         acc, done, saw_full, saw_block;
    logic [7:0] d;
    int         acc_n, max_lvl, fcount;

    // Reset behaviour, during and after the pulse
    #25;
    check("rst_txd", int'(TXD), 1);
    check("rst_ready", int'(TX_READY), 1);
    check("rst_busy", int'(BUSY), 0);
    check("rst_level", int'(FIFO_LEVEL), 0);
    #25;
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    check("post_rst_txd", int'(TXD), 1);
    check("post_rst_busy", int'(BUSY), 0);
    check("post_rst_level", int'(FIFO_LEVEL), 0);

    // Single frames
    single_frame(8'h55);
`ifdef UART_TX_PARITY_EN
    single_frame(8'h07);
    single_frame(8'h03);
`endif

    // Burst with TX_VALID held: fill, block on full, drain back to back
    rec = 1'b1;
    starts_q.delete();
    d = 8'h00;
    acc_n = 0;
    max_lvl = 0;
    done = 1'b0;
    saw_full = 1'b0;
    saw_block = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      drive_byte(d, acc);
      if (int'(FIFO_LEVEL) > max_lvl) max_lvl = int'(FIFO_LEVEL);
      if (acc) begin
        acc_n++;
        d = d + 8'd1;
        if (saw_block) begin
          check("level_after_retry_accept", int'(FIFO_LEVEL), 16);
          done = 1'b1;
        end else if (acc_n == 17) begin
          check("ready_low_when_full", int'(TX_READY), 0);
          check("level_full", int'(FIFO_LEVEL), 16);
          saw_full = 1'b1;
        end
      end else if (!saw_full) begin
        check("refused_before_full_accepts", acc_n, 17);
        saw_full = 1'b1;
      end else if (!saw_block && FIFO_LEVEL != 5'd16) begin
        check("level_after_blocked_pop", int'(FIFO_LEVEL), 15);
        check("ready_after_blocked_pop", int'(TX_READY), 1);
        saw_block = 1'b1;
      end
    end
    TX_VALID = 1'b0;
    check("burst_completed", int'(done), 1);
    check("burst_accepts", acc_n, 18);
    check("burst_max_level", max_lvl, 16);
    wait_idle(4000, "burst_drain_busy");
    rec = 1'b0;
    check("burst_drain_level", int'(FIFO_LEVEL), 0);
    check("burst_frame_count", starts_q.size(), 18);
    for (int i = 1; i < starts_q.size(); i++)
      check("burst_frame_spacing", starts_q[i] - starts_q[i-1], NB * CPB);
    check("burst_queue_empty", exp_q.size(), 0);

    // Randomized traffic with idle cycles carrying junk data
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        drive_byte(8'($urandom), acc);
      end else begin
        @(negedge CLK);
        TX_VALID = 1'b0;
        TX_DATA  = 8'($urandom);
        @(posedge CLK);
        #1;
      end
    end
    TX_VALID = 1'b0;
    wait_idle(8000, "random_drain_busy");
    check("random_queue_empty", exp_q.size(), 0);
    check("random_drain_level", int'(FIFO_LEVEL), 0);

    // Reset in the middle of data bit 3 of 0xA3 with another byte still queued
    drive_byte(8'hA3, acc);
    drive_byte(8'h5A, acc);
    TX_VALID = 1'b0;
    check("level_before_abort", int'(FIFO_LEVEL), 1);
    repeat (4 * CPB + 5) @(posedge CLK);
    #1;
    check("txd_data_bit3", int'(TXD), 0);
    #2;
    RESET = 1'b1;
    #1;
    check("abort_txd", int'(TXD), 1);
    check("abort_level", int'(FIFO_LEVEL), 0);
    check("abort_busy", int'(BUSY), 0);
    check("abort_ready", int'(TX_READY), 1);
    exp_q.delete();
    fcount = frames;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (200) @(posedge CLK);
    #1;
    check("no_frame_after_abort", frames, fcount);
    check("idle_txd_after_abort", int'(TXD), 1);
    check("idle_busy_after_abort", int'(BUSY), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
